// File: rtl/ram_port_arbiter.sv
// Two-requester single-port RAM arbiter: one pending read, one buffered write,
// read priority with a bounded starvation override for the waiting write.
module ram_port_arbiter #(
   parameter int unsigned RAM_WIDTH    = 32,
   parameter int unsigned ADDR_BITS    = 17,
   parameter int unsigned MAX_ADDR     = 129599,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rd_req,
   input  logic [ADDR_BITS-1:0] rd_addr,
   output logic                 rd_valid,
   output logic [RAM_WIDTH-1:0] rd_data,
   input  logic                 wr_req,
   input  logic [ADDR_BITS-1:0] wr_addr,
   input  logic [RAM_WIDTH-1:0] wr_data,
   output logic                 wr_busy,
   output logic                 wr_ack,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [RAM_WIDTH-1:0] ram_wdata,
   output logic                 ram_we,
   input  logic [RAM_WIDTH-1:0] ram_rdata,
   output logic                 err
);

   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [ADDR_BITS-1:0] MAX_A = ADDR_BITS'(MAX_ADDR);
   localparam logic [CNT_W-1:0]     LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE} state_t;

   state_t                 state, state_nxt;
   logic                   rd_pend;
   logic [ADDR_BITS-1:0]   rd_addr_q;
   logic                   rd_oor;
   logic [ADDR_BITS-1:0]   wr_addr_q;
   logic [RAM_WIDTH-1:0]   wr_data_q;
   logic [CNT_W-1:0]       starve_cnt;

   logic grant_rd, grant_wr;
   logic rd_acc, rd_drop, wr_acc, wr_drop;
   logic rd_addr_oor, wr_addr_oor;

   assign rd_addr_oor = (rd_addr_q > MAX_A);
   assign wr_addr_oor = (wr_addr_q > MAX_A);

   // Next-state, grant and request-acceptance decode
   always_comb begin
      state_nxt = state;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      case (state)
         IDLE: begin
            if (rd_pend && !(wr_busy && (starve_cnt == LIMIT))) begin
               grant_rd  = 1'b1;
               state_nxt = RD_ISSUE;
            end else if (wr_busy) begin
               grant_wr  = 1'b1;
               state_nxt = WR_ISSUE;
            end
         end
         RD_ISSUE:   state_nxt = RD_CAPTURE;
         RD_CAPTURE: state_nxt = IDLE;
         WR_ISSUE:   state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
      // A request landing in its own grant cycle refills the slot
      rd_acc  = rd_req && (!rd_pend || grant_rd);
      rd_drop = rd_req && !rd_acc;
      wr_acc  = wr_req && (!wr_busy || grant_wr);
      wr_drop = wr_req && !wr_acc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         rd_pend    <= 1'b0;
         rd_addr_q  <= '0;
         rd_oor     <= 1'b0;
         wr_busy    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         starve_cnt <= '0;
         rd_valid   <= 1'b0;
         rd_data    <= '0;
         wr_ack     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         ram_we     <= 1'b0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;

         if (rd_acc) begin
            rd_pend   <= 1'b1;
            rd_addr_q <= rd_addr;
         end else if (grant_rd) begin
            rd_pend <= 1'b0;
         end

         if (wr_acc) begin
            wr_busy   <= 1'b1;
            wr_addr_q <= wr_addr;
            wr_data_q <= wr_data;
         end else if (grant_wr) begin
            wr_busy <= 1'b0;
         end

         if (grant_rd) rd_oor <= rd_addr_oor;

         // Out-of-range accesses never touch the RAM port
         if (grant_rd && !rd_addr_oor) begin
            ram_addr <= rd_addr_q;
         end else if (grant_wr && !wr_addr_oor) begin
            ram_addr  <= wr_addr_q;
            ram_wdata <= wr_data_q;
         end
         ram_we <= grant_wr && !wr_addr_oor;
         wr_ack <= grant_wr;

         rd_valid <= (state == RD_CAPTURE);
         if (state == RD_CAPTURE) rd_data <= rd_oor ? '0 : ram_rdata;

         err <= rd_drop || wr_drop || (grant_wr && wr_addr_oor)
                || ((state == RD_CAPTURE) && rd_oor);

         if (!wr_busy || grant_wr) begin
            starve_cnt <= '0;
         end else if (grant_rd && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end

endmodule
